// File: rtl/glcd_pkg.sv
// Shared definitions for the KS0108-class panel controller: command bytes,
// controller FSM states and bus transaction phases.
package glcd_pkg;

  localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
  localparam logic [7:0] CMD_SET_Y      = 8'h40;
  localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;

  // Bus transactions per page during a clear: SET_PAGE, SET_Y, 64 data bytes.
  localparam int CLR_CMDS = 66;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_INIT,
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE
  } state_t;

  // Phase names record the last tick that was executed.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_T0,
    PH_T1
  } phase_t;

endpackage

// File: rtl/glcd_bus_xact.sv
// Tick divider plus 3-tick E-strobe sequencer. A start pulse queues one
// transaction; cs/rs/data are launched at T0, E is high for T1, done pulses after T2.
module glcd_bus_xact
  import glcd_pkg::*;
#(
  parameter int DIV_CYCLES = 4,
  parameter int NUM_CHIPS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_CHIPS-1:0] cmd_cs,
  input  logic                 cmd_rs,
  input  logic [7:0]           cmd_data,
  output logic                 tick,
  output logic                 done,
  output logic                 lcd_e,
  output logic                 lcd_rs,
  output logic [7:0]           lcd_data,
  output logic [NUM_CHIPS-1:0] lcd_cs
);

  localparam int DW = $clog2(DIV_CYCLES);

  logic [DW-1:0]        div_cnt;
  phase_t               phase;
  logic                 pend;
  logic [NUM_CHIPS-1:0] pend_cs;
  logic                 pend_rs;
  logic [7:0]           pend_data;

  assign tick = (div_cnt == DW'(DIV_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      phase     <= PH_IDLE;
      pend      <= 1'b0;
      pend_cs   <= '0;
      pend_rs   <= 1'b0;
      pend_data <= '0;
      done      <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      lcd_cs    <= '0;
    end else begin
      done    <= 1'b0;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (start) begin
        pend      <= 1'b1;
        pend_cs   <= cmd_cs;
        pend_rs   <= cmd_rs;
        pend_data <= cmd_data;
      end
      // The panel bus only moves on tick boundaries so setup/hold are whole ticks.
      if (tick) begin
        case (phase)
          PH_IDLE: begin
            if (pend) begin
              lcd_cs   <= pend_cs;
              lcd_rs   <= pend_rs;
              lcd_data <= pend_data;
              lcd_e    <= 1'b0;
              pend     <= 1'b0;
              phase    <= PH_T0;
            end
          end
          PH_T0: begin
            lcd_e <= 1'b1;
            phase <= PH_T1;
          end
          default: begin
            lcd_e <= 1'b0;
            done  <= 1'b1;
            phase <= PH_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/glcd_ks0108_ctrl.sv
// KS0108-class panel controller: timed panel reset, init, optional clear, then
// host byte writes with per-chip shadow addressing to skip redundant address commands.
module glcd_ks0108_ctrl
  import glcd_pkg::*;
#(
  parameter int DIV_CYCLES    = 4,
  parameter int NUM_CHIPS     = 2,
  parameter int PAGES         = 8,
  parameter int RST_TICKS     = 16,
  parameter int START_LINE    = 0,
  parameter int CLEAR_ON_INIT = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [$clog2(PAGES)-1:0]          wr_page,
  input  logic [$clog2(NUM_CHIPS*64)-1:0]   wr_col,
  input  logic [7:0]                        wr_data,
  input  logic                              clr_req,
  output logic                              init_done,
  output logic                              lcd_e,
  output logic                              lcd_rs,
  output logic                              lcd_rw,
  output logic [7:0]                        lcd_data,
  output logic [NUM_CHIPS-1:0]              lcd_cs,
  output logic                              lcd_rst
);

  localparam int PW  = $clog2(PAGES);
  localparam int CHW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;

  state_t               state;
  logic                 waiting;
  logic                 start;
  logic                 tick;
  logic                 done;
  logic [NUM_CHIPS-1:0] cmd_cs, nxt_cs;
  logic                 cmd_rs, nxt_rs;
  logic [7:0]           cmd_data, nxt_data;
  logic                 nxt_issue;
  logic [15:0]          rst_cnt;
  logic [1:0]           step;
  logic [PW-1:0]        clr_page;
  logic [6:0]           clr_idx;
  logic [PW-1:0]        lat_page;
  logic [5:0]           lat_y;
  logic [CHW-1:0]       lat_chip;
  logic [7:0]           lat_data;
  logic [PW-1:0]        sh_page [NUM_CHIPS];
  logic [5:0]           sh_y    [NUM_CHIPS];
  logic [NUM_CHIPS-1:0] sh_vld;
  logic [31:0]          in_chip;
  logic                 in_chip_ok;
  logic                 page_hit, y_hit;

  assign lcd_rw     = 1'b0;
  assign in_chip    = 32'(wr_col) >> 6;
  assign in_chip_ok = (in_chip < 32'(NUM_CHIPS));
  assign page_hit   = sh_vld[lat_chip] && (sh_page[lat_chip] == lat_page);
  assign y_hit      = sh_vld[lat_chip] && (sh_y[lat_chip] == lat_y);

  glcd_bus_xact #(
    .DIV_CYCLES (DIV_CYCLES),
    .NUM_CHIPS  (NUM_CHIPS)
  ) u_bus (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cmd_cs   (cmd_cs),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .tick     (tick),
    .done     (done),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .lcd_cs   (lcd_cs)
  );

  always_comb begin
    nxt_issue = 1'b0;
    nxt_cs    = '1;
    nxt_rs    = 1'b0;
    nxt_data  = 8'h00;
    case (state)
      ST_INIT: begin
        nxt_issue = 1'b1;
        case (step)
          2'd0:    nxt_data = CMD_DISP_ON;
          2'd1:    nxt_data = CMD_START_LINE | 8'(START_LINE % 64);
          2'd2:    nxt_data = CMD_SET_PAGE;
          default: nxt_data = CMD_SET_Y;
        endcase
      end
      ST_CLEAR: begin
        nxt_issue = 1'b1;
        if (clr_idx == 7'd0)      nxt_data = CMD_SET_PAGE | 8'(clr_page);
        else if (clr_idx == 7'd1) nxt_data = CMD_SET_Y;
        else                      nxt_rs   = 1'b1;
      end
      ST_WRITE: begin
        nxt_cs = NUM_CHIPS'(1) << lat_chip;
        case (step)
          2'd0: begin
            nxt_data  = CMD_SET_PAGE | 8'(lat_page);
            nxt_issue = !page_hit;
          end
          2'd1: begin
            nxt_data  = CMD_SET_Y | {2'b00, lat_y};
            nxt_issue = !y_hit;
          end
          default: begin
            nxt_rs    = 1'b1;
            nxt_data  = lat_data;
            nxt_issue = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST_HOLD;
      waiting   <= 1'b0;
      start     <= 1'b0;
      cmd_cs    <= '0;
      cmd_rs    <= 1'b0;
      cmd_data  <= '0;
      rst_cnt   <= '0;
      step      <= '0;
      clr_page  <= '0;
      clr_idx   <= '0;
      lat_page  <= '0;
      lat_y     <= '0;
      lat_chip  <= '0;
      lat_data  <= '0;
      sh_vld    <= '0;
      for (int i = 0; i < NUM_CHIPS; i++) begin
        sh_page[i] <= '0;
        sh_y[i]    <= '0;
      end
      lcd_rst   <= 1'b0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      start <= 1'b0;
      if (!waiting && nxt_issue) begin
        start    <= 1'b1;
        waiting  <= 1'b1;
        cmd_cs   <= nxt_cs;
        cmd_rs   <= nxt_rs;
        cmd_data <= nxt_data;
      end
      if (waiting && done) waiting <= 1'b0;

      case (state)
        ST_RST_HOLD: begin
          if (tick) begin
            if (rst_cnt == 16'(RST_TICKS - 1)) begin
              rst_cnt <= '0;
              lcd_rst <= 1'b1;
              state   <= ST_RST_WAIT;
            end else begin
              rst_cnt <= rst_cnt + 16'd1;
            end
          end
        end
        ST_RST_WAIT: begin
          if (tick) begin
            if (rst_cnt == 16'(RST_TICKS - 1)) begin
              rst_cnt <= '0;
              step    <= '0;
              state   <= ST_INIT;
            end else begin
              rst_cnt <= rst_cnt + 16'd1;
            end
          end
        end
        ST_INIT: begin
          if (waiting && done) begin
            if (step == 2'd3) begin
              clr_page <= '0;
              clr_idx  <= '0;
              if (CLEAR_ON_INIT != 0) begin
                state <= ST_CLEAR;
              end else begin
                state     <= ST_IDLE;
                wr_ready  <= 1'b1;
                init_done <= 1'b1;
              end
            end else begin
              step <= step + 2'd1;
            end
          end
        end
        ST_CLEAR: begin
          if (waiting && done) begin
            if (clr_idx == 7'(CLR_CMDS - 1)) begin
              clr_idx <= '0;
              if (clr_page == PW'(PAGES - 1)) begin
                state     <= ST_IDLE;
                wr_ready  <= 1'b1;
                init_done <= 1'b1;
                sh_vld    <= '0;
              end else begin
                clr_page <= clr_page + PW'(1);
              end
            end else begin
              clr_idx <= clr_idx + 7'd1;
            end
          end
        end
        ST_IDLE: begin
          // A dropped out-of-range write leaves ready low for one cycle only.
          if (!wr_ready) begin
            wr_ready <= 1'b1;
          end else if (clr_req) begin
            wr_ready <= 1'b0;
            clr_page <= '0;
            clr_idx  <= '0;
            state    <= ST_CLEAR;
          end else if (wr_valid) begin
            wr_ready <= 1'b0;
            lat_page <= wr_page;
            lat_y    <= wr_col[5:0];
            lat_chip <= CHW'(in_chip);
            lat_data <= wr_data;
            step     <= '0;
            if (in_chip_ok) state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (waiting && done) begin
            case (step)
              2'd0: begin
                sh_page[lat_chip] <= lat_page;
                step              <= 2'd1;
              end
              2'd1: begin
                sh_y[lat_chip] <= lat_y;
                step           <= 2'd2;
              end
              default: begin
                // Panel Y auto-increments and wraps at 64 after every data byte.
                sh_page[lat_chip] <= lat_page;
                sh_y[lat_chip]    <= lat_y + 6'd1;
                sh_vld[lat_chip]  <= 1'b1;
                wr_ready          <= 1'b1;
                state             <= ST_IDLE;
              end
            endcase
          end else if (!waiting && !nxt_issue) begin
            step <= step + 2'd1;
          end
        end
        default: state <= ST_RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_glcd_ks0108_ctrl.sv
// Bench for glcd_ks0108_ctrl: bus transactions decoded on lcd_e falling edge
// and compared against an expected-transaction queue.
module tb_glcd_ks0108_ctrl;

  localparam int CLK_P = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       clr_req = 1'b0;
  logic [2:0] wr_page = '0;
  logic [6:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, init_done, lcd_e, lcd_rs, lcd_rw, lcd_rst;
  logic [7:0] lcd_data;
  logic [1:0] lcd_cs;

  always #(CLK_P / 2) clk = ~clk;

  glcd_ks0108_ctrl #(
    .DIV_CYCLES    (4),
    .NUM_CHIPS     (2),
    .PAGES         (8),
    .RST_TICKS     (2),
    .START_LINE    (0),
    .CLEAR_ON_INIT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_page   (wr_page),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .init_done (init_done),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .lcd_cs    (lcd_cs),
    .lcd_rst   (lcd_rst)
  );

  typedef struct packed {
    logic [1:0] cs;
    logic       rs;
    logic [7:0] data;
  } bus_t;

  typedef struct {
    logic [2:0] page;
    logic [6:0] col;
    logic [7:0] data;
    logic       send_page;
    logic       send_y;
  } wr_vec_t;

  bus_t    exp_q[$];
  bus_t    obs_q[$];
  wr_vec_t vecs[10];
  int      checks = 0;
  int      failures = 0;
  int      rises = 0;
  time     t_fall = 0;

  always @(negedge lcd_e) begin
    if (rst_n) begin
      obs_q.push_back({lcd_cs, lcd_rs, lcd_data});
      t_fall = $time;
    end
  end

  always @(posedge init_done) rises++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [1:0] cs, input logic rs, input logic [7:0] data);
    exp_q.push_back({cs, rs, data});
  endtask

  task automatic push_init();
    push(2'b11, 1'b0, 8'h3F);
    push(2'b11, 1'b0, 8'hC0);
    push(2'b11, 1'b0, 8'hB8);
    push(2'b11, 1'b0, 8'h40);
  endtask

  task automatic push_clear();
    for (int p = 0; p < 8; p++) begin
      push(2'b11, 1'b0, 8'hB8 | 8'(p));
      push(2'b11, 1'b0, 8'h40);
      for (int k = 0; k < 64; k++) push(2'b11, 1'b1, 8'h00);
    end
  endtask

  task automatic drain(input string name);
    bus_t o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_unexpected: got cs=%b rs=%b data=%h expected no transaction",
                 name, o.cs, o.rs, o.data);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL %s_bus: got cs=%b rs=%b data=%h expected cs=%b rs=%b data=%h",
                   name, o.cs, o.rs, o.data, e.cs, e.rs, e.data);
        end
      end
    end
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (!wr_ready && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_ready_timeout"}, 64'(wr_ready), 64'(1));
  endtask

  task automatic reset_release_and_init(input string name);
    int n = 0;
    push_init();
    push_clear();
    @(negedge clk);
    rst_n = 1'b1;
    while (!lcd_rst && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_lcd_rst_low_clks"}, 64'(n), 64'(8));
    n = 0;
    while (!init_done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 40) begin
        check({name, "_ready_before_init"}, 64'(wr_ready), 64'(0));
        @(negedge clk);
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        @(negedge clk);
        clr_req  = 1'b0;
        wr_valid = 1'b0;
      end
    end
    check({name, "_init_done"}, 64'(init_done), 64'(1));
    drain(name);
    check({name, "_init_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({name, "_ready_at_init_done"}, 64'(wr_ready), 64'(1));
  endtask

  task automatic do_write(input logic [2:0] page, input logic [6:0] col, input logic [7:0] data,
                          input logic send_page, input logic send_y, input string name);
    logic [1:0] cs;
    logic [6:0] c;
    c  = col;
    cs = (c >= 7'd64) ? 2'b10 : 2'b01;
    if (send_page) push(cs, 1'b0, 8'hB8 | {5'b0, page});
    if (send_y)    push(cs, 1'b0, 8'h40 | {2'b0, c[5:0]});
    push(cs, 1'b1, data);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_page  = page;
    wr_col   = col;
    wr_data  = data;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check({name, "_ready_low"}, 64'(wr_ready), 64'(0));
    wait_ready(300, name);
    check({name, "_ready_latency"}, 64'($time - 1 - t_fall), 64'(CLK_P));
    drain(name);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    vecs[0] = '{3'd3, 7'd70,  8'hA5, 1'b1, 1'b1};
    vecs[1] = '{3'd3, 7'd71,  8'h5A, 1'b0, 1'b0};
    vecs[2] = '{3'd3, 7'd5,   8'h11, 1'b1, 1'b1};
    vecs[3] = '{3'd3, 7'd6,   8'h22, 1'b0, 1'b0};
    vecs[4] = '{3'd4, 7'd7,   8'h33, 1'b1, 1'b0};
    vecs[5] = '{3'd3, 7'd72,  8'h44, 1'b0, 1'b0};
    vecs[6] = '{3'd3, 7'd127, 8'h55, 1'b0, 1'b1};
    vecs[7] = '{3'd3, 7'd64,  8'h66, 1'b0, 1'b0};
    vecs[8] = '{3'd7, 7'd0,   8'h77, 1'b1, 1'b1};
    vecs[9] = '{3'd0, 7'd63,  8'h88, 1'b1, 1'b1};

    #23;
    check("reset_bus", 64'({lcd_e, lcd_rs, lcd_rw, lcd_data, lcd_cs}), 64'(0));
    check("reset_ctrl", 64'({lcd_rst, wr_ready, init_done}), 64'(0));

    reset_release_and_init("init1");
    check("init_done_rises_once", 64'(rises), 64'(1));

    for (int i = 0; i < 10; i++)
      do_write(vecs[i].page, vecs[i].col, vecs[i].data, vecs[i].send_page, vecs[i].send_y,
               $sformatf("vec%0d", i));

    // Clear and write requested together: clear wins.
    push_clear();
    @(negedge clk);
    wr_valid = 1'b1;
    clr_req  = 1'b1;
    wr_page  = 3'd1;
    wr_col   = 7'd1;
    wr_data  = 8'hEE;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    check("clr_ready_low", 64'(wr_ready), 64'(0));
    wait_ready(10000, "clr");
    drain("clr");
    check("clr_queue_empty", 64'(exp_q.size()), 64'(0));
    check("init_done_after_clr", 64'(init_done), 64'(1));

    do_write(3'd3, 7'd65, 8'h99, 1'b1, 1'b1, "post_clear");

    // Reset asserted in the middle of the E pulse of a data write.
    push(2'b01, 1'b0, 8'hBA);
    push(2'b01, 1'b0, 8'h4A);
    push(2'b01, 1'b1, 8'hC3);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_page  = 3'd2;
    wr_col   = 7'd10;
    wr_data  = 8'hC3;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    n = 0;
    while (!(lcd_e && lcd_rs) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midT1_reached", 64'({lcd_e, lcd_rs}), 64'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    check("midT1_reset_bus", 64'({lcd_e, lcd_rs, lcd_rw, lcd_data, lcd_cs}), 64'(0));
    check("midT1_reset_ctrl", 64'({lcd_rst, wr_ready, init_done}), 64'(0));
    drain("midT1");
    check("midT1_data_not_decoded", 64'(exp_q.size()), 64'(1));
    exp_q.delete();
    obs_q.delete();

    reset_release_and_init("init2");
    check("init_done_rises_again", 64'(rises), 64'(2));
    do_write(3'd5, 7'd100, 8'h3C, 1'b1, 1'b1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
